router_reg_param: RTL and testbench

Parametrised successor to the router's datapath register block. Sits between the router FSM and the output FIFOs, and performs these functions:
- latches the header;
- holds the byte that arrives while the FIFO is full;
- drives dout to the FIFO write port;
- checks each packet's trailer, either by XOR parity or by CRC.

Beyond the previous generation, it adds:
- configurable data width, address width and port count;
- a CRC check mode;
- a payload byte counter;
- a length-mismatch error derived from the header length field.

---
 rtl/router_pkg.sv | 41 ++++
 rtl/router_chk_acc.sv | 47 ++++
 rtl/router_reg_param.sv | 132 +++++++++++++
 tb/tb_router_reg_param.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants and helpers for the parametrised router register block:
// check-mode selectors, default geometry, header field slicing and the CRC byte step.
package router_pkg;

    localparam int CHECK_XOR     = 0;
    localparam int CHECK_CRC     = 1;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 2;
    localparam int DEF_NUM_PORTS = 3;

    // Header fields are returned zero-extended to 32 bits so callers of any width can compare them.
    function automatic logic [31:0] hdr_addr(input logic [31:0] hdr, input int addr_w);
        return hdr & ((32'd1 << addr_w) - 32'd1);
    endfunction

    function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int addr_w);
        return hdr >> addr_w;
    endfunction

    // One MSB-first CRC step over a width-bit byte; the poly's top bit is implicit.
    function automatic logic [31:0] crc_step(input logic [31:0] crc_in, input logic [31:0] data,
                                             input logic [31:0] poly, input int width);
        logic [31:0] mask;
        logic [31:0] msb;
        logic [31:0] c;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        msb  = 32'd1 << (width - 1);
        c    = (crc_in ^ data) & mask;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                if ((c & msb) != 32'd0) begin
                    c = ((c << 1) ^ poly) & mask;
                end else begin
                    c = (c << 1) & mask;
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/router_chk_acc.sv
// Packet check accumulator: clears on a new packet and folds one byte per enabled
// cycle, either by XOR or by a single CRC byte step.
module router_chk_acc
    import router_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                FOLD_MODE = CHECK_XOR,
    parameter logic [DATA_W-1:0] CRC_POLY  = DATA_W'(8'h07)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              fold_en,
    input  logic [DATA_W-1:0] fold_data,
    output logic [DATA_W-1:0] chk
);

    logic [DATA_W-1:0] fold_res_s;
    logic [DATA_W-1:0] chk_next_s;

    // Fold result for the selected mode, then clear > fold > hold selection.
    always_comb begin
        fold_res_s = chk ^ fold_data;
        chk_next_s = chk;
        case (FOLD_MODE)
            CHECK_CRC: fold_res_s = DATA_W'(crc_step(32'(chk), 32'(fold_data), 32'(CRC_POLY), DATA_W));
            default:   fold_res_s = chk ^ fold_data;
        endcase
        if (clear) begin
            chk_next_s = '0;
        end else if (fold_en) begin
            chk_next_s = fold_res_s;
        end else begin
            chk_next_s = chk;
        end
    end

    // Accumulator register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chk <= '0;
        end else begin
            chk <= chk_next_s;
        end
    end

endmodule

// File: rtl/router_reg_param.sv
// Router datapath register block: header latch, full-byte hold, FIFO write data,
// trailer check (XOR or CRC), payload counting and length check.
module router_reg_param
    import router_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                NUM_PORTS  = DEF_NUM_PORTS,
    parameter int                CHECK_MODE = CHECK_XOR,
    parameter logic [DATA_W-1:0] CRC_POLY   = DATA_W'(8'h07)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     pkt_valid,
    input  logic                     fifo_full,
    input  logic                     rst_int_reg,
    input  logic                     detect_add,
    input  logic                     lfd_state,
    input  logic                     ld_state,
    input  logic                     laf_state,
    input  logic                     full_state,
    input  logic [DATA_W-1:0]        data_in,
    output logic [DATA_W-1:0]        dout,
    output logic                     parity_done,
    output logic                     low_pkt_valid,
    output logic                     err,
    output logic                     len_err,
    output logic [DATA_W-ADDR_W-1:0] byte_cnt
);

    localparam int CNT_W = DATA_W - ADDR_W;

    logic [DATA_W-1:0] hold_hdr_r;
    logic [DATA_W-1:0] ffb_r;
    logic [DATA_W-1:0] rx_chk_r;
    logic [DATA_W-1:0] chk_acc_s;
    logic [DATA_W-1:0] fold_data_s;
    logic              done_d_r;
    logic              hdr_ok_s;
    logic              pay_fold_s;
    logic              fold_en_s;
    logic              trl_take_s;
    logic              pdone_set_s;
    logic              len_mismatch_s;

    assign hdr_ok_s       = detect_add && pkt_valid &&
                            (hdr_addr(32'(data_in), ADDR_W) < 32'(NUM_PORTS));
    assign pay_fold_s     = ld_state && pkt_valid && !full_state;
    assign fold_en_s      = lfd_state || pay_fold_s;
    assign fold_data_s    = lfd_state ? hold_hdr_r : data_in;
    assign trl_take_s     = ld_state && !fifo_full && !pkt_valid;
    assign pdone_set_s    = trl_take_s || (laf_state && low_pkt_valid && !parity_done);
    assign len_mismatch_s = 32'(byte_cnt) != hdr_len(32'(hold_hdr_r), ADDR_W);

    router_chk_acc #(
        .DATA_W    (DATA_W),
        .FOLD_MODE (CHECK_MODE),
        .CRC_POLY  (CRC_POLY)
    ) u_chk_acc (
        .clock     (clock),
        .reset     (reset),
        .clear     (detect_add),
        .fold_en   (fold_en_s),
        .fold_data (fold_data_s),
        .chk       (chk_acc_s)
    );

    // Byte path: header latch, full-byte hold, received check byte and FIFO write data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_hdr_r <= '0;
            ffb_r      <= '0;
            rx_chk_r   <= '0;
            dout       <= '0;
        end else begin
            if (hdr_ok_s) begin
                hold_hdr_r <= data_in;
            end
            if (lfd_state) begin
                dout <= hold_hdr_r;
            end else if (ld_state && !fifo_full) begin
                dout <= data_in;
            end else if (laf_state) begin
                dout <= ffb_r;
            end
            if (ld_state && fifo_full) begin
                ffb_r <= data_in;
            end
            if (trl_take_s) begin
                rx_chk_r <= data_in;
            end
        end
    end

    // Packet status; err/len_err are evaluated once, the cycle after parity_done rises.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_cnt      <= '0;
            low_pkt_valid <= 1'b0;
            parity_done   <= 1'b0;
            done_d_r      <= 1'b0;
            err           <= 1'b0;
            len_err       <= 1'b0;
        end else begin
            if (detect_add) begin
                byte_cnt <= '0;
            end else if (pay_fold_s && (byte_cnt != {CNT_W{1'b1}})) begin
                byte_cnt <= byte_cnt + CNT_W'(1);
            end
            if (rst_int_reg) begin
                low_pkt_valid <= 1'b0;
            end else if (ld_state && !pkt_valid) begin
                low_pkt_valid <= 1'b1;
            end
            if (detect_add) begin
                parity_done <= 1'b0;
            end else if (pdone_set_s) begin
                parity_done <= 1'b1;
            end
            if (detect_add) begin
                done_d_r <= 1'b0;
                err      <= 1'b0;
                len_err  <= 1'b0;
            end else if (parity_done && !done_d_r) begin
                done_d_r <= 1'b1;
                err      <= (chk_acc_s != rx_chk_r);
                len_err  <= len_mismatch_s;
            end
        end
    end

endmodule

// File: tb/tb_router_reg_param.sv
// Bench for router_reg_param: an XOR and a CRC instance share one stimulus stream and
// are compared every cycle against a packet-level model, plus directed literal checks.
module tb_router_reg_param;
    import router_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pkt_valid = 1'b0, fifo_full = 1'b0, rst_int_reg = 1'b0;
    logic       detect_add = 1'b0, lfd_state = 1'b0, ld_state = 1'b0;
    logic       laf_state = 1'b0, full_state = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] dout_x, dout_c;
    logic       pdone_x, pdone_c, low_x, low_c, err_x, err_c, lerr_x, lerr_c;
    logic [5:0] cnt_x, cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: packet-level view of what has been received
    logic [7:0] m_hdr, m_ffb, m_rx, m_dout;
    logic [7:0] m_bytes[$];
    int         m_npay;
    logic       m_low, m_pdone, m_done, m_lerr;
    logic       m_err[2];
    logic [7:0] pay_q[$];

    router_reg_param #(.DATA_W(8), .ADDR_W(2), .NUM_PORTS(3), .CHECK_MODE(CHECK_XOR), .CRC_POLY(8'h07)) u_xor (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .rst_int_reg(rst_int_reg), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state), .data_in(data_in),
        .dout(dout_x), .parity_done(pdone_x), .low_pkt_valid(low_x), .err(err_x),
        .len_err(lerr_x), .byte_cnt(cnt_x));

    router_reg_param #(.DATA_W(8), .ADDR_W(2), .NUM_PORTS(3), .CHECK_MODE(CHECK_CRC), .CRC_POLY(8'h07)) u_crc (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .rst_int_reg(rst_int_reg), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state), .data_in(data_in),
        .dout(dout_c), .parity_done(pdone_c), .low_pkt_valid(low_c), .err(err_c),
        .len_err(lerr_c), .byte_cnt(cnt_c));

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_acc(input int mode);
        logic [7:0] c;
        c = 8'h00;
        foreach (m_bytes[i]) begin
            if (mode == 0) c = c ^ m_bytes[i];
            else           c = 8'(crc_step(32'(c), 32'(m_bytes[i]), 32'h07, 8));
        end
        return c;
    endfunction

    function automatic logic [7:0] model_cnt();
        return (m_npay > 63) ? 8'd63 : 8'(m_npay);
    endfunction

    task automatic model_reset();
        m_hdr = 8'h00; m_ffb = 8'h00; m_rx = 8'h00; m_dout = 8'h00;
        m_bytes.delete(); m_npay = 0;
        m_low = 1'b0; m_pdone = 1'b0; m_done = 1'b0; m_lerr = 1'b0;
        m_err[0] = 1'b0; m_err[1] = 1'b0;
    endtask

    // Apply the block's rules to the inputs just sampled; status reads pre-edge values first.
    task automatic model_edge();
        logic [7:0] d;
        logic       evaluate;
        d = data_in;
        evaluate = m_pdone && !m_done;
        if (detect_add) begin
            m_done = 1'b0; m_err[0] = 1'b0; m_err[1] = 1'b0; m_lerr = 1'b0;
        end else if (evaluate) begin
            m_done   = 1'b1;
            m_err[0] = (model_acc(0) != m_rx);
            m_err[1] = (model_acc(1) != m_rx);
            m_lerr   = (model_cnt() != (m_hdr / 8'd4));
        end
        if (detect_add) m_pdone = 1'b0;
        else if ((ld_state && !fifo_full && !pkt_valid) || (laf_state && m_low && !m_pdone)) m_pdone = 1'b1;
        if (rst_int_reg) m_low = 1'b0;
        else if (ld_state && !pkt_valid) m_low = 1'b1;
        if (ld_state && !fifo_full && !pkt_valid) m_rx = d;
        if (lfd_state) m_dout = m_hdr;
        else if (ld_state && !fifo_full) m_dout = d;
        else if (laf_state) m_dout = m_ffb;
        if (ld_state && fifo_full) m_ffb = d;
        if (detect_add) begin
            m_bytes.delete(); m_npay = 0;
        end else if (lfd_state) begin
            m_bytes.push_back(m_hdr);
        end else if (ld_state && pkt_valid && !full_state) begin
            m_bytes.push_back(d); m_npay++;
        end
        if (detect_add && pkt_valid && ((d % 8'd4) < 8'd3)) m_hdr = d;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        check("dout_x", 32'(dout_x), 32'(m_dout));
        check("dout_c", 32'(dout_c), 32'(m_dout));
        check("pdone_x", 32'(pdone_x), 32'(m_pdone));
        check("pdone_c", 32'(pdone_c), 32'(m_pdone));
        check("low_x", 32'(low_x), 32'(m_low));
        check("low_c", 32'(low_c), 32'(m_low));
        check("err_x", 32'(err_x), 32'(m_err[0]));
        check("err_c", 32'(err_c), 32'(m_err[1]));
        check("len_err_x", 32'(lerr_x), 32'(m_lerr));
        check("len_err_c", 32'(lerr_c), 32'(m_lerr));
        check("byte_cnt_x", 32'(cnt_x), 32'(model_cnt()));
        check("byte_cnt_c", 32'(cnt_c), 32'(model_cnt()));
    end

    task automatic cyc();
        @(posedge clock);
        #1;
        if (reset) model_reset();
        else       model_edge();
    endtask

    task automatic idle();
        pkt_valid = 1'b0; fifo_full = 1'b0; rst_int_reg = 1'b0; detect_add = 1'b0;
        lfd_state = 1'b0; ld_state = 1'b0; laf_state = 1'b0; full_state = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic do_full(input logic pv);
        int k;
        k = 1 + int'($urandom % 2);
        idle(); full_state = 1'b1; fifo_full = 1'b1; pkt_valid = pv;
        repeat (k) cyc();
        idle(); laf_state = 1'b1; pkt_valid = pv;
        cyc();
    endtask

    task automatic send_packet(input logic [7:0] hdr, input logic [7:0] trl, input int full_at,
                               input logic trl_full, input logic trl_rst);
        idle(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr; cyc();
        idle(); lfd_state = 1'b1; pkt_valid = 1'b1; cyc();
        foreach (pay_q[i]) begin
            idle(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = pay_q[i];
            fifo_full = (i == full_at); cyc();
            if (i == full_at) do_full(1'b1);
        end
        idle(); ld_state = 1'b1; data_in = trl; fifo_full = trl_full; rst_int_reg = trl_rst; cyc();
        if (trl_full) do_full(1'b0);
        idle(); cyc(); cyc();
    endtask

    initial begin
        logic [7:0] hdr, trl;
        logic [31:0] t;
        int n, sel, full_at;
        model_reset();
        #1;
        check("reset_dout", 32'(dout_x), 32'h0);
        check("reset_pdone", 32'(pdone_x), 32'h0);
        check("reset_cnt", 32'(cnt_c), 32'h0);
        @(posedge clock); #1; reset = 1'b0; idle();

        // good XOR packet
        pay_q = '{8'h07, 8'h08, 8'h01};
        send_packet(8'h0D, 8'h03, -1, 1'b0, 1'b0);
        check("tp1_model_xor", 32'(model_acc(0)), 32'h03);
        check("tp1_err", 32'(err_x), 32'h0);
        check("tp1_len_err", 32'(lerr_x), 32'h0);
        check("tp1_cnt", 32'(cnt_x), 32'h3);
        check("tp1_pdone", 32'(pdone_x), 32'h1);
        check("tp1_dout_trl", 32'(dout_x), 32'h03);
        idle(); rst_int_reg = 1'b1; cyc();

        // bad parity, err sticky
        send_packet(8'h0D, 8'h04, -1, 1'b0, 1'b0);
        check("tp2_err", 32'(err_x), 32'h1);
        idle(); cyc(); cyc();
        check("tp2_err_held", 32'(err_x), 32'h1);

        // length mismatch
        send_packet(8'h11, 8'h1F, -1, 1'b0, 1'b1);
        check("tp3_len_err", 32'(lerr_x), 32'h1);
        check("tp3_err", 32'(err_x), 32'h0);

        // FIFO full mid-payload and on the trailer
        idle(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h09; cyc();
        idle(); lfd_state = 1'b1; pkt_valid = 1'b1; cyc();
        idle(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h05; cyc();
        idle(); ld_state = 1'b1; pkt_valid = 1'b1; fifo_full = 1'b1; data_in = 8'h02; cyc();
        check("tp4_dout_full", 32'(dout_x), 32'h05);
        idle(); full_state = 1'b1; fifo_full = 1'b1; pkt_valid = 1'b1; cyc();
        check("tp4_dout_full2", 32'(dout_x), 32'h05);
        idle(); laf_state = 1'b1; pkt_valid = 1'b1; cyc();
        check("tp4_dout_laf", 32'(dout_x), 32'h02);
        idle(); ld_state = 1'b1; fifo_full = 1'b1; data_in = 8'h0E; cyc();
        check("tp4_low", 32'(low_x), 32'h1);
        check("tp4_pdone_wait", 32'(pdone_x), 32'h0);
        idle(); full_state = 1'b1; fifo_full = 1'b1; cyc();
        idle(); laf_state = 1'b1; cyc();
        check("tp4_pdone_laf", 32'(pdone_x), 32'h1);
        check("tp4_dout_ffb", 32'(dout_x), 32'h0E);
        idle(); rst_int_reg = 1'b1; cyc();
        check("tp5_low_clr", 32'(low_x), 32'h0);

        // invalid address keeps the header; clear beats set on low_pkt_valid
        idle(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h0F; cyc();
        idle(); lfd_state = 1'b1; pkt_valid = 1'b1; cyc();
        check("tp5_hold_hdr", 32'(dout_x), 32'h09);
        idle(); ld_state = 1'b1; rst_int_reg = 1'b1; cyc();
        check("tp5_low_both", 32'(low_x), 32'h0);
        idle(); cyc();

        // CRC mode
        pay_q = '{8'h00};
        send_packet(8'h05, 8'h41, -1, 1'b0, 1'b1);
        check("tp6_model_crc", 32'(model_acc(1)), 32'h41);
        check("tp6_crc_good", 32'(err_c), 32'h0);
        send_packet(8'h05, 8'h40, -1, 1'b0, 1'b1);
        check("tp6_crc_bad", 32'(err_c), 32'h1);

        // byte counter saturates at 63, matching header length 63
        pay_q.delete();
        for (int i = 0; i < 66; i++) pay_q.push_back(8'(i));
        send_packet(8'hFD, 8'h00, -1, 1'b0, 1'b1);
        check("sat_cnt", 32'(cnt_x), 32'd63);
        check("sat_len_err", 32'(lerr_x), 32'h0);

        // randomized packets
        for (int p = 0; p < 40; p++) begin
            n = 1 + int'($urandom % 6);
            pay_q.delete();
            for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
            hdr = 8'($urandom);
            sel = int'($urandom % 3);
            if (sel == 0) begin
                trl = hdr;
                foreach (pay_q[i]) trl = trl ^ pay_q[i];
            end else if (sel == 1) begin
                t = crc_step(32'h0, 32'(hdr), 32'h07, 8);
                foreach (pay_q[i]) t = crc_step(t, 32'(pay_q[i]), 32'h07, 8);
                trl = 8'(t);
            end else begin
                trl = 8'($urandom);
            end
            full_at = (($urandom % 3) == 0) ? int'($urandom % 32'(n)) : -1;
            send_packet(hdr, trl, full_at, (($urandom % 4) == 0), (($urandom % 4) == 0));
            if (($urandom % 2) == 0) begin
                idle(); rst_int_reg = 1'b1; cyc();
            end
        end

        // asynchronous reset mid-payload
        idle(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h0D; cyc();
        idle(); lfd_state = 1'b1; pkt_valid = 1'b1; cyc();
        idle(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h07; cyc();
        #2; reset = 1'b1; #1;
        model_reset();
        check("arst_dout_x", 32'(dout_x), 32'h0);
        check("arst_dout_c", 32'(dout_c), 32'h0);
        check("arst_cnt_x", 32'(cnt_x), 32'h0);
        check("arst_low_c", 32'(low_c), 32'h0);
        @(posedge clock); #1; reset = 1'b0; idle();
        pay_q = '{8'h07, 8'h08, 8'h01};
        send_packet(8'h0D, 8'h03, -1, 1'b0, 1'b1);
        check("post_rst_err", 32'(err_x), 32'h0);
        check("post_rst_cnt", 32'(cnt_x), 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
